// File: rtl/mps_rdo_pkg.sv
// rtl/mps_rdo_pkg.sv - readout word types, FSM states and output word packing
// Output width and parity bit are selected by MPS_RDO_PARITY_EN.
package mps_rdo_pkg;

  typedef enum logic [1:0] {
    WT_IDLE = 2'b00,
    WT_HIT  = 2'b01,
    WT_HDR  = 2'b10,
    WT_TRL  = 2'b11
  } word_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_ARB,
    ST_READ,
    ST_CAPT,
    ST_SEND,
    ST_TRL
  } rdo_state_e;

`ifdef MPS_RDO_PARITY_EN
  localparam int OUT_W = 19;
`else
  localparam int OUT_W = 18;
`endif

  function automatic logic [OUT_W-1:0] pack_word(word_type_e t, logic [15:0] p);
`ifdef MPS_RDO_PARITY_EN
    return {^{t, p}, t, p};
`else
    return {t, p};
`endif
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant: first request at or after ptr
module rr_arbiter #(
  parameter int N_COL = 4,
  parameter int COLW  = $clog2(N_COL)
) (
  input  logic [N_COL-1:0] req_i,
  input  logic [COLW-1:0]  ptr_i,
  output logic [N_COL-1:0] grant_o,
  output logic [COLW-1:0]  idx_o
);

  logic [COLW-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    cand    = '0;
    // Scan farthest offset first so the nearest request overwrites it.
    for (int i = N_COL - 1; i >= 0; i--) begin
      cand = ptr_i + COLW'(i);
      if (req_i[cand]) begin
        idx_o       = cand;
        grant_o     = '0;
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/col_readout_arbiter.sv
// rtl/col_readout_arbiter.sv - frame readout sequencer draining column hit FIFOs
// Optional even parity on out_data[18] when MPS_RDO_PARITY_EN is defined.
module col_readout_arbiter
  import mps_rdo_pkg::*;
#(
  parameter int N_COL    = 4,
  parameter int COLW     = $clog2(N_COL),
  parameter int DW       = 14,
  parameter int MAX_HITS = 1024
) (
  input  logic                systemclk,
  input  logic                sys_reset,
  input  logic                frame_start,
  input  logic [N_COL-1:0]    col_mask,
  input  logic [N_COL-1:0]    col_empty,
  output logic [N_COL-1:0]    col_rd_en,
  input  logic [N_COL*DW-1:0] col_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic                busy,
  output logic                frame_drop
);

  rdo_state_e       state_q;
  logic [15:0]      frame_cnt_q;
  logic [14:0]      hit_cnt_q;
  logic [COLW-1:0]  rr_ptr_q;
  logic [COLW-1:0]  grant_idx_q;
  logic [N_COL-1:0] mask_q;
  logic [N_COL-1:0] rd_en_q;
  logic             pending_q;
  logic             frame_drop_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] out_data_q;

  logic [N_COL-1:0] req;
  logic [N_COL-1:0] grant;
  logic [COLW-1:0]  grant_idx;
  logic             xfer;

  assign req  = ~col_empty & mask_q;
  assign xfer = out_valid_q & out_ready;

  rr_arbiter #(.N_COL(N_COL), .COLW(COLW)) u_rr (
    .req_i  (req),
    .ptr_i  (rr_ptr_q),
    .grant_o(grant),
    .idx_o  (grant_idx)
  );

  always_ff @(posedge systemclk) begin
    if (!sys_reset) begin
      state_q      <= ST_IDLE;
      frame_cnt_q  <= '0;
      hit_cnt_q    <= '0;
      rr_ptr_q     <= '0;
      grant_idx_q  <= '0;
      mask_q       <= '0;
      rd_en_q      <= '0;
      pending_q    <= 1'b0;
      frame_drop_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      // One frame request can queue behind the running frame; more are lost.
      if (frame_start && state_q != ST_IDLE) begin
        if (!pending_q) pending_q    <= 1'b1;
        else            frame_drop_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (frame_start || pending_q) begin
            mask_q      <= col_mask;
            hit_cnt_q   <= '0;
            pending_q   <= 1'b0;
            out_valid_q <= 1'b1;
            out_data_q  <= pack_word(WT_HDR, frame_cnt_q);
            state_q     <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (xfer) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            out_valid_q <= 1'b0;
            state_q     <= ST_ARB;
          end
        end
        ST_ARB: begin
          if (req == '0 || hit_cnt_q == 15'(MAX_HITS)) begin
            out_valid_q <= 1'b1;
            out_data_q  <= pack_word(WT_TRL, {req != '0, hit_cnt_q});
            state_q     <= ST_TRL;
          end else begin
            rd_en_q     <= grant;
            grant_idx_q <= grant_idx;
            rr_ptr_q    <= grant_idx + COLW'(1);
            state_q     <= ST_READ;
          end
        end
        ST_READ: begin
          rd_en_q <= '0;
          state_q <= ST_CAPT;
        end
        ST_CAPT: begin
          out_valid_q <= 1'b1;
          out_data_q  <= pack_word(WT_HIT, 16'({grant_idx_q, col_data[grant_idx_q*DW +: DW]}));
          state_q     <= ST_SEND;
        end
        ST_SEND: begin
          if (xfer) begin
            hit_cnt_q   <= hit_cnt_q + 15'd1;
            out_valid_q <= 1'b0;
            state_q     <= ST_ARB;
          end
        end
        ST_TRL: begin
          if (xfer) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign col_rd_en  = rd_en_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_drop = frame_drop_q;

endmodule
